// File: rtl/piso_sched.sv
// Arbitrates two word requesters and feeds the winning word, two bits at a time,
// to a 2-bit serializer, waiting for its completion pulse between symbols.
module piso_sched #(
   parameter int WORD_W  = 8,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   input  logic [WORD_W-1:0] req_data0,
   input  logic [WORD_W-1:0] req_data1,
   output logic [1:0]        req_ready,
   output logic [1:0]        sym,
   output logic              sym_valid,
   input  logic              piso_done,
   output logic              grant_id,
   output logic              busy,
   output logic              word_done,
   output logic              err_timeout,
   output logic [1:0]        state_o
);

   localparam int SYM_N = WORD_W / 2;
   localparam int CNT_W = (SYM_N > 1) ? $clog2(SYM_N) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t            state_q;
   logic [WORD_W-1:0] sr_q;
   logic [WORD_W-1:0] sr_shift;
   logic [WORD_W-1:0] win_data;
   logic [CNT_W-1:0]  cnt_q;
   logic [TMO_W-1:0]  tmo_q;
   logic [1:0]        sym_q;
   logic              sym_valid_q;
   logic              grant_q;
   logic              last_q;
   logic              word_done_q;
   logic              err_q;
   logic              winner;
   logic              xfer;

   // Handshake: a requester's word moves on a rising edge where its req_valid and
   // req_ready are both high; req_ready is raised for one winner, only in IDLE.
   always_comb begin
      winner = 1'b0;
      case (req_valid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_q;
         default: winner = 1'b0;
      endcase
      req_ready = 2'b00;
      if (state_q == S_IDLE && rst_n && (|req_valid)) req_ready[winner] = 1'b1;
   end

   assign xfer     = |(req_valid & req_ready);
   assign win_data = winner ? req_data1 : req_data0;
   assign sr_shift = sr_q >> 2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         sym_q       <= 2'b00;
         sym_valid_q <= 1'b0;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         word_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sym_valid_q <= 1'b0;
         word_done_q <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  sr_q        <= win_data;
                  sym_q       <= win_data[1:0];
                  grant_q     <= winner;
                  last_q      <= winner;
                  cnt_q       <= '0;
                  sym_valid_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmo_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Completion wins over a timeout expiring in the same cycle.
               if (piso_done) begin
                  if (cnt_q == CNT_W'(SYM_N - 1)) begin
                     word_done_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     sr_q        <= sr_shift;
                     sym_q       <= sr_shift[1:0];
                     cnt_q       <= cnt_q + 1'b1;
                     sym_valid_q <= 1'b1;
                     state_q     <= S_ISSUE;
                  end
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sym         = sym_q;
   assign sym_valid   = sym_valid_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q != S_IDLE);
   assign word_done   = word_done_q;
   assign err_timeout = err_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_piso_sched.sv
// Directed bench for piso_sched with a 3-cycle serializer model and a symbol scoreboard.
module tb_piso_sched;

   localparam int WORD_W  = 8;
   localparam int TIMEOUT = 8;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [WORD_W-1:0] req_data0;
   logic [WORD_W-1:0] req_data1;
   logic [1:0]        req_ready;
   logic [1:0]        sym;
   logic              sym_valid;
   logic              piso_done;
   logic              grant_id;
   logic              busy;
   logic              word_done;
   logic              err_timeout;
   logic [1:0]        state_o;

   logic              model_en;
   logic              model_done;
   logic              force_done;
   logic              st1;
   logic              st2;
   logic [1:0]        got_q[$];
   logic [1:0]        exp_q[$];

   int n_checks;
   int n_pass;
   int n_fail;

   piso_sched #(.WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data0   (req_data0),
      .req_data1   (req_data1),
      .req_ready   (req_ready),
      .sym         (sym),
      .sym_valid   (sym_valid),
      .piso_done   (piso_done),
      .grant_id    (grant_id),
      .busy        (busy),
      .word_done   (word_done),
      .err_timeout (err_timeout),
      .state_o     (state_o)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign piso_done = model_done | force_done;

   // Serializer model: strobe cycle, busy cycle (samples sym), done cycle.
   always @(negedge clk) begin
      model_done = model_en && st2;
      st2 = st1;
      st1 = sym_valid;
      if (st2) got_q.push_back(sym);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      int n;
      int cyc;
      int words;
      int idle_run;
      logic prev_busy;
      logic saw11;
      logic saw_wd;
      logic [1:0] grants[$];
      logic exp_g[4];

      n_checks = 0; n_pass = 0; n_fail = 0;
      model_en = 1'b0; model_done = 1'b0; force_done = 1'b0; st1 = 1'b0; st2 = 1'b0;
      rst_n = 1'b0; req_valid = 2'b01; req_data0 = '0; req_data1 = '0;

      // Reset state, with a request pending that must not be acknowledged
      #3;
      chk("rst req_ready", req_ready, 2'b00);
      chk("rst sym_valid", sym_valid, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst state", state_o, 2'd0);
      chk("rst sym", sym, 2'b00);
      req_valid = 2'b00;
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Single word 8'hB4 -> symbols 0,1,3,2, data0 scrambled after acceptance
      model_en = 1'b1;
      got_q.delete();
      req_valid = 2'b01; req_data0 = 8'hB4;
      #1;
      chk("single req_ready", req_ready, 2'b01);
      tick(1);
      req_valid = 2'b00;
      chk("single sym_valid", sym_valid, 1'b1);
      chk("single first sym", sym, 2'd0);
      chk("single grant", grant_id, 1'b0);
      n = 0;
      while (n < 40 && !word_done) begin
         req_data0 = WORD_W'($urandom_range(0, 255));
         tick(1);
         n++;
      end
      // Pulse occupies the 13th cycle counted from the accept edge.
      chk("single latency", n, 12);
      exp_q = '{2'd0, 2'd1, 2'd3, 2'd2};
      chk("single sym count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("single sym", got_q[i], exp_q[i]);
      tick(1);
      chk("single pulse width", word_done, 1'b0);
      chk("single idle", busy, 1'b0);

      // Timeout: serializer silent, both requesters valid; 0 was served last -> 1 wins
      model_en = 1'b0;
      req_valid = 2'b11; req_data0 = 8'h12; req_data1 = 8'h34;
      #1;
      chk("tmo req_ready", req_ready, 2'b10);
      tick(1);
      chk("tmo grant", grant_id, 1'b1);
      n = 0; saw_wd = 1'b0;
      while (n < 40 && !err_timeout) begin
         if (word_done) saw_wd = 1'b1;
         tick(1);
         n++;
      end
      // ISSUE cycle plus TIMEOUT cycles in WAIT, then the pulse.
      chk("tmo latency", n, TIMEOUT + 1);
      chk("tmo no word_done", saw_wd | word_done, 1'b0);
      chk("tmo idle", busy, 1'b0);
      chk("tmo next grant", req_ready, 2'b01);
      req_valid = 2'b00;
      tick(1);
      chk("tmo pulse width", err_timeout, 1'b0);

      // Contention: both valid, grants alternate starting with 0, one IDLE gap
      model_en = 1'b1;
      got_q.delete();
      req_data0 = 8'h00; req_data1 = 8'hFF;
      req_valid = 2'b11;
      words = 0; idle_run = 0; prev_busy = 1'b0; saw11 = 1'b0; cyc = 0;
      while (words < 4 && cyc < 200) begin
         tick(1);
         cyc++;
         if (req_ready == 2'b11) saw11 = 1'b1;
         if (busy && !prev_busy) begin
            grants.push_back({1'b0, grant_id});
            if (words > 0) chk("cont idle gap", idle_run, 1);
            words++;
            idle_run = 0;
            if (words == 4) req_valid = 2'b00;
         end else if (!busy) begin
            idle_run++;
         end
         prev_busy = busy;
      end
      cyc = 0;
      while (busy && cyc < 40) begin
         if (req_ready == 2'b11) saw11 = 1'b1;
         tick(1);
         cyc++;
      end
      chk("cont drained", busy, 1'b0);
      chk("cont words", words, 4);
      chk("cont ready onehot", saw11, 1'b0);
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4 && i < grants.size(); i++)
         chk("cont grant", grants[i], {1'b0, exp_g[i]});
      exp_q.delete();
      for (int w = 0; w < 4; w++)
         for (int s = 0; s < 4; s++)
            exp_q.push_back(exp_g[w] ? 2'd3 : 2'd0);
      chk("cont sym count", got_q.size(), 16);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("cont sym", got_q[i], exp_q[i]);

      // Done on the expiry cycle: symbol completes, no timeout; word 8'hE4 from requester 1
      model_en = 1'b0;
      req_valid = 2'b10; req_data1 = 8'hE4;
      tick(1);
      req_valid = 2'b00;
      chk("sim grant", grant_id, 1'b1);
      tick(TIMEOUT);
      force_done = 1'b1;
      tick(1);
      force_done = 1'b0;
      chk("sim no err", err_timeout, 1'b0);
      chk("sim reissue", sym_valid, 1'b1);
      chk("sim state", state_o, 2'd1);
      chk("sim second sym", sym, 2'd1);

      // Reset during the second WAIT clears outputs asynchronously
      tick(1);
      chk("mid busy", busy, 1'b1);
      req_valid = 2'b11;
      rst_n = 1'b0;
      #1;
      chk("mid rst busy", busy, 1'b0);
      chk("mid rst grant", grant_id, 1'b0);
      chk("mid rst sym", sym, 2'b00);
      chk("mid rst sym_valid", sym_valid, 1'b0);
      chk("mid rst req_ready", req_ready, 2'b00);
      chk("mid rst pulses", {word_done, err_timeout}, 2'b00);
      tick(2);
      rst_n = 1'b1;
      #1;
      chk("post rst tie", req_ready, 2'b01);
      tick(1);
      req_valid = 2'b00;
      chk("post rst grant", grant_id, 1'b0);
      model_en = 1'b1;
      cyc = 0;
      while (busy && cyc < 60) begin
         tick(1);
         cyc++;
      end
      chk("post rst drained", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
